// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_PC = 3'd1,
    MEM_WAIT = 3'd2,
    MDR_LOAD = 3'd3,
    IR_LOAD  = 3'd4
  } state_e;

  localparam logic MEM_RW_READ_DEFAULT = 1'b1;

  // mem_acc marks the states that drive MEM_RW to its read level
  typedef struct packed {
    logic pc_read;
    logic mar_write;
    logic mar_mem_read;
    logic mem_acc;
    logic mem_en;
    logic mdr_mem_write;
    logic mdr_read;
    logic ir_write;
  } strobe_t;

  function automatic strobe_t decode_strobes(input state_e s);
    strobe_t st;
    st = '0;
    case (s)
      FETCH_PC: begin
        st.pc_read   = 1'b1;
        st.mar_write = 1'b1;
      end
      MEM_WAIT: begin
        st.mar_mem_read = 1'b1;
        st.mem_acc      = 1'b1;
        st.mem_en       = 1'b1;
      end
      MDR_LOAD: begin
        st.mar_mem_read  = 1'b1;
        st.mem_acc       = 1'b1;
        st.mem_en        = 1'b1;
        st.mdr_mem_write = 1'b1;
      end
      IR_LOAD: begin
        st.mdr_read = 1'b1;
        st.ir_write = 1'b1;
      end
      default: st = '0;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/fetch_start_sync.sv
// Captures asynchronous start pulses as a toggle and brings them into the clk
// domain; pending stays high until the FSM acknowledges by toggling ack.
module fetch_start_sync
  import fetch_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ack_i,
  output logic pending_o
);

  logic req_q;
  logic sync1_q;
  logic sync2_q;
  logic ack_q;

  // The start pulse itself is the clock, so pulses shorter than a clk period are never lost
  always_ff @(posedge start or negedge reset) begin
    if (!reset) begin
      req_q <= 1'b0;
    end else begin
      req_q <= ~req_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      sync1_q <= req_q;
      sync2_q <= sync1_q;
      ack_q   <= ack_q ^ ack_i;
    end
  end

  assign pending_o = sync2_q ^ ack_q;

endmodule

// File: rtl/fetch_fsm.sv
// Instruction-fetch control FSM: PC->MAR, memory read, wait MFC, mem->MDR, MDR->IR.
// Optional FETCH_BUSY_EN adds a busy output (state != IDLE or request pending).
module fetch_fsm
  import fetch_pkg::*;
#(
  parameter logic MEM_RW_READ = MEM_RW_READ_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic MFC,
  output logic PC_read,
  output logic MAR_write,
  output logic MAR_mem_read,
  output logic MEM_RW,
  output logic MEM_EN,
  output logic MDR_mem_write,
  output logic MDR_read,
  output logic IR_write
`ifdef FETCH_BUSY_EN
  ,
  output logic busy
`endif
);

  state_e  state_q;
  state_e  state_d;
  strobe_t strobe_q;
  strobe_t strobe_d;
  logic    mem_rw_q;
  logic    mem_rw_d;
  logic    pending_s;
  logic    ack_s;

  fetch_start_sync u_start_sync (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ack_i    (ack_s),
    .pending_o(pending_s)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_s) begin
          state_d = FETCH_PC;
          ack_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      FETCH_PC: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (MFC) begin
          state_d = MDR_LOAD;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      MDR_LOAD: state_d = IR_LOAD;
      IR_LOAD: begin
        if (pending_s) begin
          state_d = FETCH_PC;
          ack_s   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so they track state_q exactly
  always_comb begin
    strobe_d = decode_strobes(state_d);
    mem_rw_d = strobe_d.mem_acc ? MEM_RW_READ : ~MEM_RW_READ;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      strobe_q <= '0;
      mem_rw_q <= ~MEM_RW_READ;
    end else begin
      strobe_q <= strobe_d;
      mem_rw_q <= mem_rw_d;
    end
  end

  assign PC_read       = strobe_q.pc_read;
  assign MAR_write     = strobe_q.mar_write;
  assign MAR_mem_read  = strobe_q.mar_mem_read;
  assign MEM_RW        = mem_rw_q;
  assign MEM_EN        = strobe_q.mem_en;
  assign MDR_mem_write = strobe_q.mdr_mem_write;
  assign MDR_read      = strobe_q.mdr_read;
  assign IR_write      = strobe_q.ir_write;

`ifdef FETCH_BUSY_EN
  assign busy = (state_q != IDLE) | pending_s;
`endif

endmodule

// File: tb/tb_fetch_fsm.sv
// Scoreboard bench for fetch_fsm: directed start/MFC stimulus pushes expected
// strobe vectors; a negedge monitor pops and compares them.
module tb_fetch_fsm;

  localparam logic [7:0] V_IDLE = 8'b0000_0000;
  localparam logic [7:0] V_FPC  = 8'b1100_0000;
  localparam logic [7:0] V_MW   = 8'b0011_1000;
  localparam logic [7:0] V_MDR  = 8'b0011_1100;
  localparam logic [7:0] V_IR   = 8'b0000_0011;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic MFC   = 1'b0;
  logic PC_read, MAR_write, MAR_mem_read, MEM_RW, MEM_EN;
  logic MDR_mem_write, MDR_read, IR_write;
`ifdef FETCH_BUSY_EN
  logic busy;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  bit mon_en = 1'b0;
  logic [7:0] vec_s;

  fetch_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .MFC          (MFC),
    .PC_read      (PC_read),
    .MAR_write    (MAR_write),
    .MAR_mem_read (MAR_mem_read),
    .MEM_RW       (MEM_RW),
    .MEM_EN       (MEM_EN),
    .MDR_mem_write(MDR_mem_write),
    .MDR_read     (MDR_read),
    .IR_write     (IR_write)
`ifdef FETCH_BUSY_EN
    ,
    .busy         (busy)
`endif
  );

  always #10 clk = ~clk;

  assign vec_s = {PC_read, MAR_write, MAR_mem_read, MEM_RW, MEM_EN,
                  MDR_mem_write, MDR_read, IR_write};

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any non-idle vector, or the return to idle, is a DUT output event
  initial begin
    logic [7:0] prev_v;
    logic [7:0] e;
    prev_v = V_IDLE;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (vec_s != V_IDLE || prev_v != V_IDLE) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected actual=%b expected=<none> t=%0t", vec_s, $time);
          end else begin
            e = exp_q.pop_front();
            chk("sb_strobes", vec_s, e);
          end
        end
        prev_v = vec_s;
      end else begin
        prev_v = V_IDLE;
      end
    end
  end

  task automatic push_fetch(input int mw);
    exp_q.push_back(V_FPC);
    for (int i = 0; i < mw; i++) exp_q.push_back(V_MW);
    exp_q.push_back(V_MDR);
    exp_q.push_back(V_IR);
  endtask

  task automatic pulse(input int w);
    @(posedge clk);
    #2 start = 1'b1;
    #(w) start = 1'b0;
  endtask

  task automatic wait_vec(input logic [7:0] target, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (vec_s == target) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_vec actual=%b expected=%b (timeout)", vec_s, target);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d_left expected=0_left", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    // Reset state
    #25;
    chk("reset_state", vec_s, V_IDLE);
`ifdef FETCH_BUSY_EN
    chk("reset_busy", {7'd0, busy}, 8'd0);
`endif
    @(negedge clk);
    reset  = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    // T1: 10 ns pulse, MFC already high, check 3-edge latency
    MFC = 1'b1;
    push_fetch(1);
    exp_q.push_back(V_IDLE);
    pulse(10);
    repeat (2) @(posedge clk);
    #1 chk("latency_idle", vec_s, V_IDLE);
`ifdef FETCH_BUSY_EN
    chk("busy_pending", {7'd0, busy}, 8'd1);
`endif
    @(posedge clk);
    #1 chk("latency_fetch", vec_s, V_FPC);
    drain(30);
    chk("t1_idle", vec_s, V_IDLE);
`ifdef FETCH_BUSY_EN
    chk("busy_idle", {7'd0, busy}, 8'd0);
`endif

    // T2: MFC low for 5 MEM_WAIT edges -> 6 MEM_WAIT cycles
    MFC = 1'b0;
    push_fetch(6);
    exp_q.push_back(V_IDLE);
    pulse(10);
    wait_vec(V_FPC, 10);
    repeat (6) @(posedge clk);
    #1 MFC = 1'b1;
    drain(30);

    // T3: second 5 ns pulse during MEM_WAIT -> back-to-back fetch, no idle gap
    MFC = 1'b0;
    push_fetch(6);
    push_fetch(1);
    exp_q.push_back(V_IDLE);
    pulse(10);
    wait_vec(V_FPC, 10);
    @(posedge clk);
    pulse(5);
    repeat (4) @(posedge clk);
    #1 MFC = 1'b1;
    drain(40);

    // T4: three pulses during one fetch -> exactly one extra fetch
    MFC = 1'b0;
    push_fetch(6);
    push_fetch(1);
    exp_q.push_back(V_IDLE);
    pulse(10);
    wait_vec(V_FPC, 10);
    @(posedge clk);
    pulse(5);
    pulse(5);
    pulse(5);
    repeat (2) @(posedge clk);
    #1 MFC = 1'b1;
    drain(40);
    repeat (6) @(negedge clk);
    chk("t4_no_third", vec_s, V_IDLE);

    // T5: stray MFC in IDLE and FETCH_PC is ignored
    for (int i = 0; i < 4; i++) begin
      MFC = 1'b1;
      @(posedge clk);
      #3 MFC = 1'b0;
      @(negedge clk);
      chk("mfc_idle", vec_s, V_IDLE);
    end
    push_fetch(2);
    exp_q.push_back(V_IDLE);
    pulse(10);
    wait_vec(V_FPC, 10);
    MFC = 1'b1;
    #3 MFC = 1'b0;
    repeat (2) @(posedge clk);
    #1 MFC = 1'b1;
    drain(30);

    // T6: reset low mid-MEM_WAIT forces idle strobes at once
    mon_en = 1'b0;
    MFC    = 1'b0;
    pulse(10);
    wait_vec(V_MW, 10);
    #3 reset = 1'b0;
    #1 chk("reset_mid_fetch", vec_s, V_IDLE);
`ifdef FETCH_BUSY_EN
    chk("reset_mid_busy", {7'd0, busy}, 8'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_idle", vec_s, V_IDLE);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
